// File: rtl/button_pkg.sv
// Shared definitions for the push-button controller.
// Holds the FSM state encoding used by button_mode_ctrl. Encodings 5..7
// are illegal and the FSM treats them as IDLE.
package button_pkg;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_PRESS_DB   = 3'd1;
    localparam logic [2:0] ST_HELD       = 3'd2;
    localparam logic [2:0] ST_LONG       = 3'd3;
    localparam logic [2:0] ST_RELEASE_DB = 3'd4;

    typedef enum logic [2:0] {
        S_IDLE       = ST_IDLE,
        S_PRESS_DB   = ST_PRESS_DB,
        S_HELD       = ST_HELD,
        S_LONG       = ST_LONG,
        S_RELEASE_DB = ST_RELEASE_DB
    } state_t;

endpackage

// File: rtl/button_mode_ctrl_if.sv
// Button-side signal bundle.
//   in    : raw asynchronous button level, 1 = pressed
//   run   : registered toggle level
//   press : one-cycle pulse for an accepted short press
//   clear : one-cycle pulse for a long press
// master = the side that owns the button pin (board / testbench),
// slave  = the controller.
interface button_mode_ctrl_if;
    logic in;
    logic run;
    logic press;
    logic clear;

    modport master (output in, input run, input press, input clear);
    modport slave  (input in, output run, output press, output clear);
endinterface

// File: rtl/sync_2ff.sv
// Generic 1-bit two-flop synchroniser for asynchronous levels
// (buttons, switches). Output lags input by two clk cycles.
// Ports: clk, reset (sync, active-high, clears both flops), d (async in),
// q (synchronised out).
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_reg;
    logic q_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_reg <= 1'b0;
            q_reg    <= 1'b0;
        end else begin
            meta_reg <= d;
            q_reg    <= meta_reg;
        end
    end

    assign q = q_reg;

endmodule

// File: rtl/button_mode_ctrl.sv
// Single push-button controller: synchronise, debounce, then classify each
// press as short (toggle run, pulse press) or long (pulse clear, force run
// low). All outputs are registered.
// Ports: clk, reset (sync, active-high), btn (slave modport: in -> run,
// press, clear).
module button_mode_ctrl
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int LONG_CYCLES     = 100000000,
    parameter int CNT_W           = 27
) (
    input  logic                clk,
    input  logic                reset,
    button_mode_ctrl_if.slave   btn
);

    localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    logic in_s;

    sync_2ff u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (btn.in),
        .q     (in_s)
    );

    state_t           state_reg,     state_next;
    logic [CNT_W-1:0] db_cnt_reg,    db_cnt_next;
    logic [CNT_W-1:0] hold_cnt_reg,  hold_cnt_next;
    logic             long_flag_reg, long_flag_next;
    logic             run_reg,       run_next;
    logic             press_reg,     press_next;
    logic             clear_reg,     clear_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= S_IDLE;
            db_cnt_reg    <= '0;
            hold_cnt_reg  <= '0;
            long_flag_reg <= 1'b0;
            run_reg       <= 1'b0;
            press_reg     <= 1'b0;
            clear_reg     <= 1'b0;
        end else begin
            state_reg     <= state_next;
            db_cnt_reg    <= db_cnt_next;
            hold_cnt_reg  <= hold_cnt_next;
            long_flag_reg <= long_flag_next;
            run_reg       <= run_next;
            press_reg     <= press_next;
            clear_reg     <= clear_next;
        end
    end

    // Every state change clears db_cnt, so each debounce window starts at 0.
    always_comb begin
        state_next     = state_reg;
        db_cnt_next    = db_cnt_reg;
        hold_cnt_next  = hold_cnt_reg;
        long_flag_next = long_flag_reg;
        run_next       = run_reg;
        press_next     = 1'b0;
        clear_next     = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (in_s) begin
                    state_next  = S_PRESS_DB;
                    db_cnt_next = '0;
                end
            end

            S_PRESS_DB: begin
                if (!in_s) begin
                    state_next  = S_IDLE;
                    db_cnt_next = '0;
                end else if (db_cnt_reg == DB_LAST) begin
                    state_next    = S_HELD;
                    db_cnt_next   = '0;
                    hold_cnt_next = '0;
                end else begin
                    db_cnt_next = db_cnt_reg + CNT_ONE;
                end
            end

            S_HELD: begin
                hold_cnt_next = hold_cnt_reg + CNT_ONE;
                // Release is tested first so a release coinciding with the
                // long threshold still counts as a short press.
                if (!in_s) begin
                    state_next  = S_RELEASE_DB;
                    db_cnt_next = '0;
                end else if (hold_cnt_reg == LONG_LAST) begin
                    state_next     = S_LONG;
                    db_cnt_next    = '0;
                    long_flag_next = 1'b1;
                    clear_next     = 1'b1;
                    run_next       = 1'b0;
                end
            end

            S_LONG: begin
                if (!in_s) begin
                    state_next  = S_RELEASE_DB;
                    db_cnt_next = '0;
                end
            end

            S_RELEASE_DB: begin
                // hold_cnt is left untouched here so a bounce back into HELD
                // resumes the hold measurement instead of restarting it.
                if (in_s) begin
                    state_next  = long_flag_reg ? S_LONG : S_HELD;
                    db_cnt_next = '0;
                end else if (db_cnt_reg == DB_LAST) begin
                    state_next     = S_IDLE;
                    db_cnt_next    = '0;
                    long_flag_next = 1'b0;
                    if (!long_flag_reg) begin
                        press_next = 1'b1;
                        run_next   = ~run_reg;
                    end
                end else begin
                    db_cnt_next = db_cnt_reg + CNT_ONE;
                end
            end

            default: begin
                state_next     = S_IDLE;
                db_cnt_next    = '0;
                long_flag_next = 1'b0;
            end
        endcase
    end

    assign btn.run   = run_reg;
    assign btn.press = press_reg;
    assign btn.clear = clear_reg;

endmodule

// File: tb/tb_button_mode_ctrl.sv
// Directed bench for button_mode_ctrl with DEBOUNCE_CYCLES=4,
// LONG_CYCLES=20, CNT_W=8. Inputs change on the falling edge; outputs are
// sampled on the falling edge. With cyc = number of rising edges seen so
// far, a change of in driven at cyc=c yields:
//   short press pulse (after release)  at cyc = c_fall + 7
//   clear pulse (after press)          at cyc = c_rise + 27
// (2 synchroniser edges, 1 FSM reaction, 4 debounce / 20 hold cycles).
module tb_button_mode_ctrl;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    button_mode_ctrl_if bif ();

    button_mode_ctrl #(
        .DEBOUNCE_CYCLES (4),
        .LONG_CYCLES     (20),
        .CNT_W           (8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .btn   (bif)
    );

    int cyc = 0;
    always @(posedge clk) cyc++;

    typedef struct {
        string tag;
        bit    is_clear;
        int    at;
        bit    run;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;
    bit run_m    = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Output monitor: every pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (!reset && (bif.press !== 1'b0 || bif.clear !== 1'b0)) begin
            check("press_clear_exclusive", 32'(bif.press & bif.clear), 32'd0);
            if (sb.size() == 0) begin
                check("unexpected_pulse", 32'({bif.press, bif.clear}), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                check({mon_e.tag, "_kind"}, 32'({bif.press, bif.clear}),
                      mon_e.is_clear ? 32'd1 : 32'd2);
                check({mon_e.tag, "_cycle"}, 32'(cyc), 32'(mon_e.at));
                check({mon_e.tag, "_run"}, 32'(bif.run), 32'(mon_e.run));
            end
        end
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Wait (bounded) for all expected pulses, then stay quiet so the
    // monitor can catch stray pulses, then confirm the run level.
    task automatic drain(input string tag);
        int k = 0;
        while (sb.size() != 0 && k < 80) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_drain"}, 32'(sb.size()), 32'd0);
        sb.delete();
        step(12);
        check({tag, "_run_level"}, 32'(bif.run), 32'(run_m));
    endtask

    task automatic short_press(input string tag, input int high);
        bif.in = 1'b1;
        step(high);
        bif.in = 1'b0;
        run_m = ~run_m;
        sb.push_back('{tag: tag, is_clear: 1'b0, at: cyc + 7, run: run_m});
        step(10);
        drain(tag);
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        // 1: reset with button held, then re-debounce before any pulse
        reset  = 1'b1;
        bif.in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t1_reset_run",   32'(bif.run),   32'd0);
            check("t1_reset_press", 32'(bif.press), 32'd0);
            check("t1_reset_clear", 32'(bif.clear), 32'd0);
        end
        reset = 1'b0;
        step(10);
        check("t1_held_no_pulse_run", 32'(bif.run), 32'd0);
        bif.in = 1'b0;
        run_m = 1'b1;
        sb.push_back('{tag: "t1_press", is_clear: 1'b0, at: cyc + 7, run: 1'b1});
        step(10);
        drain("t1");

        // 2: glitch shorter than the debounce window
        bif.in = 1'b1;
        step(3);
        bif.in = 1'b0;
        step(12);
        drain("t2_glitch");

        // 3: two short presses toggle run twice
        short_press("t3a_short", 10);
        short_press("t3b_short", 10);

        // 4: long press with run=1
        check("t4_run_before", 32'(bif.run), 32'd1);
        bif.in = 1'b1;
        sb.push_back('{tag: "t4_clear", is_clear: 1'b1, at: cyc + 27, run: 1'b0});
        run_m = 1'b0;
        step(40);
        bif.in = 1'b0;
        drain("t4_long");

        // 5: release bounce 0,1,0 (two cycles each) then stays low
        bif.in = 1'b1;
        step(12);
        bif.in = 1'b0;
        step(2);
        bif.in = 1'b1;
        step(2);
        bif.in = 1'b0;
        run_m = ~run_m;
        sb.push_back('{tag: "t5_bounce", is_clear: 1'b0, at: cyc + 7, run: run_m});
        step(10);
        drain("t5");

        // 6a: release reaches the FSM the same cycle hold_cnt hits 19 -> short
        short_press("t6a_boundary", 24);

        // 6b: one cycle longer -> long press, no press on release
        bif.in = 1'b1;
        sb.push_back('{tag: "t6b_long", is_clear: 1'b1, at: cyc + 27, run: 1'b0});
        run_m = 1'b0;
        step(25);
        bif.in = 1'b0;
        drain("t6b");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
